// File: rtl/reg_write_scoreboard.sv
// Pending register-write scoreboard for the pipelined MIPS datapath.
// Ports: Clk/Reset, decode issue (IssueValid/IssueRegWrite/IssueDst),
//   decode sources (UseA/SrcA/UseB/SrcB), writeback (WbValid/WbDst),
//   Flush; outputs Stall (comb), Busy (comb from state), InFlight (reg).
module reg_write_scoreboard #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IssueValid,
    input  logic        IssueRegWrite,
    input  logic [4:0]  IssueDst,
    input  logic        UseA,
    input  logic [4:0]  SrcA,
    input  logic        UseB,
    input  logic [4:0]  SrcB,
    input  logic        WbValid,
    input  logic [4:0]  WbDst,
    input  logic        Flush,
    output logic        Stall,
    output logic [31:0] Busy,
    output logic [5:0]  InFlight
);

    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt [32];

    logic byp_a;
    logic byp_b;
    logic hz_a;
    logic hz_b;
    logic hz_d;
    logic iss;
    logic ret;

    always_comb begin
        Busy    = '0;
        for (int r = 1; r < 32; r++) begin
            Busy[r] = |cnt[r];
        end
    end

    // Bypass: the last pending write retires now, and the register file
    // writes before it reads, so the source value is already correct.
    assign byp_a = WB_BYPASS && WbValid && (WbDst == SrcA) && (cnt[SrcA] == ONE);
    assign byp_b = WB_BYPASS && WbValid && (WbDst == SrcB) && (cnt[SrcB] == ONE);

    assign hz_a = UseA && (SrcA != 5'd0) && Busy[SrcA] && !byp_a;
    assign hz_b = UseB && (SrcB != 5'd0) && Busy[SrcB] && !byp_b;

    // Counter full: only safe to issue if a retire frees a slot this cycle.
    assign hz_d = IssueValid && IssueRegWrite && (IssueDst != 5'd0)
               && (cnt[IssueDst] == CMAX)
               && !(WbValid && (WbDst == IssueDst));

    assign Stall = IssueValid && (hz_a || hz_b || hz_d);

    assign iss = IssueValid && IssueRegWrite && (IssueDst != 5'd0)
              && !Stall && !Flush;
    assign ret = WbValid && (WbDst != 5'd0) && (cnt[WbDst] != '0);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else if (Flush) begin
            for (int r = 0; r < 32; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                unique case ({iss && (IssueDst == 5'(r)), ret && (WbDst == 5'(r))})
                    2'b10:   cnt[r] <= cnt[r] + ONE;
                    2'b01:   cnt[r] <= cnt[r] - ONE;
                    default: cnt[r] <= cnt[r];
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            InFlight <= '0;
        end else if (Flush) begin
            InFlight <= '0;
        end else if (iss && !ret) begin
            if (InFlight != 6'd63) InFlight <= InFlight + 6'd1;
        end else if (ret && !iss) begin
            if (InFlight != 6'd0) InFlight <= InFlight - 6'd1;
        end
    end

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Scoreboard bench for reg_write_scoreboard: two DUTs (bypass on/off)
// driven identically, checked against a counting reference model.
module tb_reg_write_scoreboard;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        IssueValid = 1'b0;
    logic        IssueRegWrite = 1'b0;
    logic [4:0]  IssueDst = '0;
    logic        UseA = 1'b0;
    logic [4:0]  SrcA = '0;
    logic        UseB = 1'b0;
    logic [4:0]  SrcB = '0;
    logic        WbValid = 1'b0;
    logic [4:0]  WbDst = '0;
    logic        Flush = 1'b0;

    logic        stall1, stall0;
    logic [31:0] busy1, busy0;
    logic [5:0]  infl1, infl0;

    always #5 Clk = ~Clk;

    reg_write_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b1)) u_byp (
        .Clk(Clk), .Reset(Reset),
        .IssueValid(IssueValid), .IssueRegWrite(IssueRegWrite),
        .IssueDst(IssueDst), .UseA(UseA), .SrcA(SrcA),
        .UseB(UseB), .SrcB(SrcB), .WbValid(WbValid), .WbDst(WbDst),
        .Flush(Flush), .Stall(stall1), .Busy(busy1), .InFlight(infl1)
    );

    reg_write_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b0)) u_nb (
        .Clk(Clk), .Reset(Reset),
        .IssueValid(IssueValid), .IssueRegWrite(IssueRegWrite),
        .IssueDst(IssueDst), .UseA(UseA), .SrcA(SrcA),
        .UseB(UseB), .SrcB(SrcB), .WbValid(WbValid), .WbDst(WbDst),
        .Flush(Flush), .Stall(stall0), .Busy(busy0), .InFlight(infl0)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic [31:0] b1;
        logic [31:0] b0;
        logic [5:0]  i1;
        logic [5:0]  i0;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: index 1 = bypass enabled, 0 = disabled.
    int pend [2][32];
    int infl [2];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_busy(input int b);
        logic [31:0] v = '0;
        for (int r = 1; r < 32; r++) v[r] = (pend[b][r] > 0);
        return v;
    endfunction

    function automatic void model_clear();
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < 32; r++) pend[b][r] = 0;
            infl[b] = 0;
        end
    endfunction

    function automatic bit source_hz(input int b, input bit use_it,
                                     input logic [4:0] s);
        int c;
        if (!use_it || s == 5'd0) return 1'b0;
        c = pend[b][s];
        if (c == 0) return 1'b0;
        if (b == 1 && WbValid && WbDst == s && c == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit step(input int b);
        bit hzd, st, iss, ret;
        hzd = IssueValid && IssueRegWrite && IssueDst != 5'd0
           && pend[b][IssueDst] == 3 && !(WbValid && WbDst == IssueDst);
        st  = IssueValid && (source_hz(b, UseA, SrcA)
                          || source_hz(b, UseB, SrcB) || hzd);
        iss = IssueValid && IssueRegWrite && IssueDst != 5'd0 && !st && !Flush;
        ret = WbValid && WbDst != 5'd0 && pend[b][WbDst] > 0;
        if (Flush) begin
            for (int r = 0; r < 32; r++) pend[b][r] = 0;
            infl[b] = 0;
        end else begin
            if (iss) pend[b][IssueDst]++;
            if (ret) pend[b][WbDst]--;
            infl[b] = infl[b] + int'(iss) - int'(ret);
            if (infl[b] > 63) infl[b] = 63;
            if (infl[b] < 0) infl[b] = 0;
        end
        return st;
    endfunction

    task automatic drive(input bit iv, input bit irw, input logic [4:0] id,
                         input bit ua, input logic [4:0] sa,
                         input bit ub, input logic [4:0] sb,
                         input bit wv, input logic [4:0] wd, input bit fl);
        exp_t e;
        @(negedge Clk);
        IssueValid = iv; IssueRegWrite = irw; IssueDst = id;
        UseA = ua; SrcA = sa; UseB = ub; SrcB = sb;
        WbValid = wv; WbDst = wd; Flush = fl;
        e.b0 = exp_busy(0);
        e.b1 = exp_busy(1);
        e.i0 = 6'(infl[0]);
        e.i1 = 6'(infl[1]);
        e.st[0] = step(0);
        e.st[1] = step(1);
        q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset pulse between the sample point and the next rising edge.
    task automatic mid_reset();
        bit s;
        #3 Reset = 1'b0;
        #1;
        chk("rst_busy1", busy1, 32'h0);
        chk("rst_busy0", busy0, 32'h0);
        chk("rst_infl1", 32'(infl1), 32'h0);
        chk("rst_infl0", 32'(infl0), 32'h0);
        chk("rst_stall1", 32'(stall1), 32'h0);
        chk("rst_stall0", 32'(stall0), 32'h0);
        model_clear();
        Reset = 1'b1;
        // The coming edge applies the current inputs to the cleared state.
        s = step(0);
        s = step(1);
    endtask

    function automatic logic [4:0] rreg();
        int k;
        if ($urandom_range(0, 7) == 0) return 5'($urandom);
        k = $urandom_range(0, 9);
        return (k == 9) ? 5'd31 : 5'(k);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_byp", 32'(stall1), 32'(e.st[1]));
                chk("stall_nb", 32'(stall0), 32'(e.st[0]));
                chk("busy_byp", busy1, e.b1);
                chk("busy_nb", busy0, e.b0);
                chk("infl_byp", 32'(infl1), 32'(e.i1));
                chk("infl_nb", 32'(infl0), 32'(e.i0));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_clear();
        #12;
        chk("init_busy", busy1, 32'h0);
        chk("init_infl", 32'(infl1), 32'h0);
        chk("init_stall", 32'(stall1), 32'h0);
        Reset = 1'b1;

        // issue 8, then read 8
        drive(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        // same-cycle retire of 8 while reading it
        drive(1, 0, 0, 1, 8, 0, 0, 1, 8, 0);
        idle();
        // register 0 is never tracked
        drive(1, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        // fill register 5, then overflow attempts
        repeat (3) drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        idle();
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
        // flush beats issue and retire
        drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 31, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 12, 0, 0, 0, 0, 1, 3, 1);
        idle();
        // async reset with pending writes
        drive(1, 1, 4, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 4, 0, 0, 0, 0, 0);
        mid_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        idle();

        // saturate InFlight, then drain past the floor
        repeat (300)
            drive(1, 1, 5'($urandom_range(1, 31)), 0, 0, 0, 0, 0, 0, 0);
        repeat (400)
            drive(0, 0, 0, 0, 0, 0, 0, 1, 5'($urandom_range(0, 31)), 0);

        // random mix
        repeat (2000) begin
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 4) != 0, rreg(),
                  $urandom_range(0, 1), rreg(), $urandom_range(0, 1), rreg(),
                  $urandom_range(0, 1), rreg(), $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) mid_reset();
        end

        idle();
        repeat (2) @(negedge Clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
